// File: rtl/multi_debounce.sv
// N-channel push-button debouncer: a 2-flop synchronizer feeding a 4-state, tick-counted filter per channel.
// Auto-repeat of press strobes on held keys is built only when MULTI_DEBOUNCE_REPEAT_EN is defined.
module multi_debounce #(
  parameter int N         = 4,
  parameter int CNT_W     = 8,
  parameter int THRESH    = 10,
  parameter int REP_DELAY = 50,
  parameter int REP_RATE  = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         m_f,
  input  logic [N-1:0] button,
  output logic [N-1:0] db_level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_strobe
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH_LAST = CNT_W'(THRESH - 1);
`ifdef MULTI_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST    = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_RELOAD  = CNT_W'(REP_DELAY - REP_RATE);
`endif

  logic [N-1:0] sync1_q;
  logic [N-1:0] sync1_d;
  logic [N-1:0] sync2_q;
  logic [N-1:0] sync2_d;
  logic [N-1:0] s;

  state_t           st_q  [N];
  state_t           st_d  [N];
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
`ifdef MULTI_DEBOUNCE_REPEAT_EN
  logic [CNT_W-1:0] rcnt_q [N];
  logic [CNT_W-1:0] rcnt_d [N];
`endif

  logic [N-1:0] db_level_q;
  logic [N-1:0] db_level_d;
  logic [N-1:0] press_q;
  logic [N-1:0] press_d;
  logic [N-1:0] release_q;
  logic [N-1:0] release_d;

  assign s              = sync2_q;
  assign db_level       = db_level_q;
  assign press          = press_q;
  assign release_strobe = release_q;

  // Synchronizer next values: raw button into stage 1, stage 1 into stage 2.
  always_comb begin
    sync1_d = button;
    sync2_d = sync1_q;
  end

  // Per-channel filter: a level change on s always wins over a coincident tick.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      st_d[i]      = st_q[i];
      cnt_d[i]     = cnt_q[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
      rcnt_d[i]    = rcnt_q[i];
`endif
      case (st_q[i])
        ST_IDLE: begin
          cnt_d[i] = CNT_ZERO;
          if (s[i]) begin
            st_d[i] = ST_PRESS_WAIT;
          end else begin
            st_d[i] = ST_IDLE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!s[i]) begin
            st_d[i]  = ST_IDLE;
            cnt_d[i] = CNT_ZERO;
          end else if (m_f) begin
            if (cnt_q[i] == THRESH_LAST) begin
              st_d[i]    = ST_HELD;
              cnt_d[i]   = CNT_ZERO;
              press_d[i] = 1'b1;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
              rcnt_d[i]  = CNT_ZERO;
`endif
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end else begin
            cnt_d[i] = cnt_q[i];
          end
        end
        ST_HELD: begin
          if (!s[i]) begin
            st_d[i]  = ST_RELEASE_WAIT;
            cnt_d[i] = CNT_ZERO;
          end else begin
            st_d[i] = ST_HELD;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
            // First repeat after REP_DELAY ticks; the reload spaces later ones REP_RATE apart.
            if (m_f) begin
              if (rcnt_q[i] == REP_LAST) begin
                press_d[i] = 1'b1;
                rcnt_d[i]  = REP_RELOAD;
              end else begin
                rcnt_d[i] = rcnt_q[i] + CNT_ONE;
              end
            end else begin
              rcnt_d[i] = rcnt_q[i];
            end
`endif
          end
        end
        ST_RELEASE_WAIT: begin
          if (s[i]) begin
            st_d[i]   = ST_HELD;
            cnt_d[i]  = CNT_ZERO;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
            rcnt_d[i] = CNT_ZERO;
`endif
          end else if (m_f) begin
            if (cnt_q[i] == THRESH_LAST) begin
              st_d[i]      = ST_IDLE;
              cnt_d[i]     = CNT_ZERO;
              release_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end else begin
            cnt_d[i] = cnt_q[i];
          end
        end
        default: begin
          st_d[i]  = ST_IDLE;
          cnt_d[i] = CNT_ZERO;
        end
      endcase
      db_level_d[i] = (st_d[i] == ST_HELD) || (st_d[i] == ST_RELEASE_WAIT);
    end
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= {N{1'b0}};
      sync2_q    <= {N{1'b0}};
      db_level_q <= {N{1'b0}};
      press_q    <= {N{1'b0}};
      release_q  <= {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        st_q[i]   <= ST_IDLE;
        cnt_q[i]  <= CNT_ZERO;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
        rcnt_q[i] <= CNT_ZERO;
`endif
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_level_q <= db_level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      for (int i = 0; i < N; i++) begin
        st_q[i]   <= st_d[i];
        cnt_q[i]  <= cnt_d[i];
`ifdef MULTI_DEBOUNCE_REPEAT_EN
        rcnt_q[i] <= rcnt_d[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: per-cycle comparison against an event-level model plus directed literal checks.
module tb_multi_debounce;
  localparam int N         = 4;
  localparam int THRESH    = 4;
  localparam int REP_DELAY = 8;
  localparam int REP_RATE  = 4;

  logic         clk    = 1'b0;
  logic         rst    = 1'b0;
  logic         m_f    = 1'b0;
  logic [N-1:0] button = 4'b0000;
  logic [N-1:0] db_level;
  logic [N-1:0] press;
  logic [N-1:0] release_strobe;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pc [N];
  int rc [N];
  int n1001 = 0;
  int nzp   = 0;
  int ptime [8];

  multi_debounce #(
    .N(N), .CNT_W(8), .THRESH(THRESH), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)
  ) dut (
    .clk(clk), .rst(rst), .m_f(m_f), .button(button),
    .db_level(db_level), .press(press), .release_strobe(release_strobe)
  );

  always #5 clk = ~clk;

  // Model: level flips once THRESH ticks land while s has differed for at least one earlier cycle.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    int   run;
    int   ticks;
    int   h;
  } chan_t;

  chan_t        m [N];
  logic [N-1:0] m_s1;
  logic [N-1:0] m_s2;

  function automatic chan_t step(input chan_t c, input logic sv, input logic mf);
    chan_t n;
    n       = c;
    n.press = 1'b0;
    n.rel   = 1'b0;
    if (sv != c.level) begin
      if (c.run >= 1 && mf) n.ticks = c.ticks + 1;
      n.run = c.run + 1;
      n.h   = 0;
      if (n.ticks == THRESH) begin
        n.level = sv;
        n.press = sv;
        n.rel   = !sv;
        n.run   = 0;
        n.ticks = 0;
      end
    end else begin
      if (c.level && c.run == 0 && mf) begin
        n.h = c.h + 1;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
        if (n.h >= REP_DELAY && ((n.h - REP_DELAY) % REP_RATE) == 0) n.press = 1'b1;
`endif
      end
      n.run   = 0;
      n.ticks = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 <= 4'b0000;
      m_s2 <= 4'b0000;
      for (int i = 0; i < N; i++) m[i] <= '0;
    end else begin
      m_s1 <= button;
      m_s2 <= m_s1;
      for (int i = 0; i < N; i++) m[i] <= step(m[i], m_s2[i], m_f);
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    logic [N-1:0] el, ep, er;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        el[i] = m[i].level;
        ep[i] = m[i].press;
        er[i] = m[i].rel;
        pc[i] += int'(press[i]);
        rc[i] += int'(release_strobe[i]);
      end
      if (press[0] && pc[0] <= 8) ptime[pc[0]-1] = cyc;
      if (press == 4'b1001) n1001++;
      if (press != 4'b0000) nzp++;
      checks++;
      if (db_level !== el || press !== ep || release_strobe !== er) begin
        errors++;
        $display("FAIL model cyc=%0d level=%b want %b press=%b want %b release=%b want %b",
                 cyc, db_level, el, press, ep, release_strobe, er);
      end
    end
  end

  // Tick strobe: one clk wide, every 8 cycles.
  initial begin
    forever begin
      repeat (7) @(negedge clk);
      m_f = 1'b1;
      @(negedge clk);
      m_f = 1'b0;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      pc[i] = 0;
      rc[i] = 0;
    end
    n1001 = 0;
    nzp   = 0;
  endtask

  initial begin
    clr();
    wait_cyc(3);
    chk("reset_level", int'(db_level), 0);
    chk("reset_press", int'(press), 0);
    chk("reset_release", int'(release_strobe), 0);
    rst = 1'b1;
    wait_cyc(2);

    // Reset in the middle of HELD on channel 0.
    button[0] = 1'b1;
    wait_cyc(40);
    chk("t1_held_level", int'(db_level[0]), 1);
    #2 rst = 1'b0;
    #1;
    chk("t1_rst_level", int'(db_level), 0);
    chk("t1_rst_press", int'(press), 0);
    chk("t1_rst_release", int'(release_strobe), 0);
    @(negedge clk);
    rst = 1'b1;
    clr();
    wait_cyc(4);
    chk("t1_needs_new_press", int'(db_level[0]), 0);
    wait_cyc(40);
    chk("t1_repress_level", int'(db_level[0]), 1);
    chk("t1_repress_count", pc[0], 1);
    button[0] = 1'b0;
    wait_cyc(40);
    chk("t1_release_level", int'(db_level[0]), 0);

    // Clean press and release on channel 2.
    clr();
    button[2] = 1'b1;
    wait_cyc(40);
    chk("t2_press_count", pc[2], 1);
    chk("t2_level_high", int'(db_level[2]), 1);
    button[2] = 1'b0;
    wait_cyc(40);
    chk("t2_release_count", rc[2], 1);
    chk("t2_level_low", int'(db_level[2]), 0);
    chk("t2_press_once", pc[2], 1);

    // Bounce rejection on channel 1.
    clr();
    button[1] = 1'b1; wait_cyc(16);
    button[1] = 1'b0; wait_cyc(16);
    button[1] = 1'b1; wait_cyc(24);
    chk("t3_bounce_no_press", pc[1], 0);
    chk("t3_bounce_level", int'(db_level[1]), 0);
    button[1] = 1'b0; wait_cyc(16);
    button[1] = 1'b1; wait_cyc(40);
    chk("t3_stable_press", pc[1], 1);

    // Release glitch on channel 1 while held.
    clr();
    button[1] = 1'b0; wait_cyc(16);
    chk("t4_level_during_glitch", int'(db_level[1]), 1);
    button[1] = 1'b1; wait_cyc(40);
    chk("t4_no_release", rc[1], 0);
    chk("t4_level_kept", int'(db_level[1]), 1);
    button[1] = 1'b0; wait_cyc(40);
    chk("t4_real_release", rc[1], 1);

    // Simultaneous press on channels 0 and 3, then glitches at every tick phase.
    clr();
    button = 4'b1001;
    wait_cyc(40);
    chk("t5_joint_press", n1001, 1);
    chk("t5_single_cycle", nzp, 1);
    for (int k = 0; k < 8; k++) begin
      button[3] = 1'b0; wait_cyc(1);
      button[3] = 1'b1; wait_cyc(9);
    end
    chk("t5_held_glitch_no_release", rc[3], 0);
    chk("t5_held_glitch_level", int'(db_level[3]), 1);
    button = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      button[3] = 1'b1; wait_cyc(1);
      button[3] = 1'b0; wait_cyc(9);
    end
    chk("t5_wait_glitch_no_release", rc[3], 0);
    wait_cyc(40);
    chk("t5_release_ch3", rc[3], 1);
    chk("t5_release_ch0", rc[0], 1);

    // Long hold on channel 0: repeat strobes only with the repeat build.
    clr();
    button[0] = 1'b1;
    wait_cyc(170);
`ifdef MULTI_DEBOUNCE_REPEAT_EN
    chk("t6_repeat_count", pc[0], 4);
    chk("t6_first_gap", ptime[1] - ptime[0], 64);
    chk("t6_second_gap", ptime[2] - ptime[1], 32);
    chk("t6_third_gap", ptime[3] - ptime[2], 32);
`else
    chk("t6_single_press", pc[0], 1);
`endif
    button[0] = 1'b0;
    wait_cyc(40);
    chk("t6_release", rc[0], 1);
    chk("t6_level_low", int'(db_level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
